// File: rtl/phase_detector_multi.sv
// Multi-channel start/stop phase detector.
// A shared reference edge starts one delay counter per measured clock; each
// channel's own rising edge stops its counter and emits a tagged measurement.
// Every channel also reports missed edges and counter overflow.
//
// Per-channel FSM:
//   state   | meaning
//   S_IDLE  | waiting for a reference edge to arm the counter
//   S_COUNT | counting sample cycles since the arming reference edge
module phase_detector_multi #(
    parameter int NUM_CH           = 4,
    parameter int phase_count_size = 12,
    parameter int ref_count_size   = 4
) (
    input  logic                                                 clk_sample,
    input  logic                                                 rst,
    input  logic                                                 clk_in_ref,
    input  logic [NUM_CH-1:0]                                    clk_in,
    input  logic                                                 enable,
    output logic [NUM_CH*(ref_count_size+phase_count_size)-1:0]  phase_tag,
    output logic [NUM_CH-1:0]                                    phase_tag_valid,
    output logic [NUM_CH*2-1:0]                                  phase_err
);

    localparam int TAG_W = ref_count_size + phase_count_size;
    localparam logic [phase_count_size-1:0] COUNT_MAX  = '1;
    localparam logic [phase_count_size-1:0] COUNT_ZERO = '0;
    localparam logic [phase_count_size-1:0] COUNT_ONE  = {{(phase_count_size-1){1'b0}}, 1'b1};
    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISSED   = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;

    typedef enum logic {S_IDLE, S_COUNT} state_t;

    logic                      ref_sync1, ref_sync2, ref_dly;
    logic [NUM_CH-1:0]         ch_sync1, ch_sync2, ch_dly;
    logic                      ref_edge;
    logic [NUM_CH-1:0]         ch_edge;
    logic [ref_count_size-1:0] ref_count;

    // Two-flop synchronizers plus one delay flop for rising-edge detection.
    // These keep running while disabled so re-enabling never sees a stale edge.
    always_ff @(posedge clk_sample or posedge rst) begin
        if (rst) begin
            ref_sync1 <= 1'b0;
            ref_sync2 <= 1'b0;
            ref_dly   <= 1'b0;
            ch_sync1  <= '0;
            ch_sync2  <= '0;
            ch_dly    <= '0;
        end else begin
            ref_sync1 <= clk_in_ref;
            ref_sync2 <= ref_sync1;
            ref_dly   <= ref_sync2;
            ch_sync1  <= clk_in;
            ch_sync2  <= ch_sync1;
            ch_dly    <= ch_sync2;
        end
    end

    assign ref_edge = ref_sync2 & ~ref_dly;
    assign ch_edge  = ch_sync2 & ~ch_dly;

    // Reference-edge counter embedded in every tag; frozen while disabled.
    always_ff @(posedge clk_sample or posedge rst) begin
        if (rst) begin
            ref_count <= '0;
        end else if (enable && ref_edge) begin
            ref_count <= ref_count + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t                    state;
        logic [phase_count_size-1:0] count;
        logic [ref_count_size-1:0] ref_latched;
        logic [TAG_W-1:0]          tag_q;
        logic [1:0]                err_q;
        logic                      valid_q;

        // Channel FSM: arm on reference edge, report on channel edge, missed edge or overflow.
        always_ff @(posedge clk_sample or posedge rst) begin
            if (rst) begin
                state       <= S_IDLE;
                count       <= COUNT_ZERO;
                ref_latched <= '0;
                tag_q       <= '0;
                err_q       <= ERR_OK;
                valid_q     <= 1'b0;
            end else begin
                valid_q <= 1'b0;
                if (!enable) begin
                    state <= S_IDLE;
                    count <= COUNT_ZERO;
                end else begin
                    case (state)
                        S_IDLE: begin
                            if (ref_edge && ch_edge[i]) begin
                                valid_q <= 1'b1;
                                tag_q   <= {ref_count, COUNT_ZERO};
                                err_q   <= ERR_OK;
                            end else if (ref_edge) begin
                                count       <= COUNT_ONE;
                                ref_latched <= ref_count;
                                state       <= S_COUNT;
                            end
                        end
                        S_COUNT: begin
                            if (ch_edge[i]) begin
                                valid_q <= 1'b1;
                                tag_q   <= {ref_latched, count};
                                err_q   <= ERR_OK;
                                if (ref_edge) begin
                                    ref_latched <= ref_count;
                                    count       <= COUNT_ONE;
                                end else begin
                                    count <= COUNT_ZERO;
                                    state <= S_IDLE;
                                end
                            end else if (ref_edge) begin
                                // New reference edge before the channel edge: report and re-arm.
                                valid_q     <= 1'b1;
                                tag_q       <= {ref_latched, count};
                                err_q       <= ERR_MISSED;
                                ref_latched <= ref_count;
                                count       <= COUNT_ONE;
                            end else if (count == COUNT_MAX) begin
                                valid_q <= 1'b1;
                                tag_q   <= {ref_latched, COUNT_MAX};
                                err_q   <= ERR_OVERFLOW;
                                count   <= COUNT_ZERO;
                                state   <= S_IDLE;
                            end else begin
                                count <= count + 1'b1;
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end

        assign phase_tag[i*TAG_W +: TAG_W] = tag_q;
        assign phase_err[i*2 +: 2]         = err_q;
        assign phase_tag_valid[i]          = valid_q;
    end

endmodule

// File: tb/tb_phase_detector_multi.sv
// Directed bench: a default-size instance plus a narrow instance
// (4-bit count, 2-bit reference counter) driven from the same stimulus.
module tb_phase_detector_multi;

    localparam int NCH  = 4;
    localparam int TW_B = 16;
    localparam int TW_S = 6;

    logic               clk_sample = 1'b0;
    logic               rst;
    logic               clk_in_ref;
    logic [NCH-1:0]     clk_in;
    logic               enable;
    logic [NCH*TW_B-1:0] tag_b;
    logic [NCH-1:0]     valid_b;
    logic [NCH*2-1:0]   err_b;
    logic [NCH*TW_S-1:0] tag_s;
    logic [NCH-1:0]     valid_s;
    logic [NCH*2-1:0]   err_s;

    int errors = 0;
    int checks = 0;

    phase_detector_multi #(.NUM_CH(4), .phase_count_size(12), .ref_count_size(4)) dut_big (
        .clk_sample      (clk_sample),
        .rst             (rst),
        .clk_in_ref      (clk_in_ref),
        .clk_in          (clk_in),
        .enable          (enable),
        .phase_tag       (tag_b),
        .phase_tag_valid (valid_b),
        .phase_err       (err_b)
    );

    phase_detector_multi #(.NUM_CH(4), .phase_count_size(4), .ref_count_size(2)) dut_small (
        .clk_sample      (clk_sample),
        .rst             (rst),
        .clk_in_ref      (clk_in_ref),
        .clk_in          (clk_in),
        .enable          (enable),
        .phase_tag       (tag_s),
        .phase_tag_valid (valid_s),
        .phase_err       (err_s)
    );

    always #5 clk_sample = ~clk_sample;

    typedef struct {
        logic [3:0]  ch_mask;
        int          dly;
        logic [3:0]  exp_valid;
        logic [11:0] exp_count;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] tag_big(input int ch);
        return tag_b[ch*TW_B +: TW_B];
    endfunction

    function automatic logic [5:0] tag_sml(input int ch);
        return tag_s[ch*TW_S +: TW_S];
    endfunction

    function automatic logic [1:0] err_big(input int ch);
        return err_b[ch*2 +: 2];
    endfunction

    function automatic logic [1:0] err_sml(input int ch);
        return err_s[ch*2 +: 2];
    endfunction

    task automatic tick();
        @(posedge clk_sample);
        #1;
    endtask

    // Advance n cycles and require no valid pulse on the selected instances.
    task automatic quiet(input int n, input bit cb, input bit cs, input string name);
        logic [3:0] sb, ss;
        sb = '0;
        ss = '0;
        for (int k = 0; k < n; k++) begin
            tick();
            sb |= valid_b;
            ss |= valid_s;
        end
        if (cb) check({name, "_big"}, sb, 0);
        if (cs) check({name, "_small"}, ss, 0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        clk_in_ref = 1'b0;
        clk_in     = '0;
        enable     = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] seen;
        logic [3:0] exp_v;

        vecs[0] = '{4'b0001, 10,  4'b0001, 12'd10,  2'b00};
        vecs[1] = '{4'b1111, 0,   4'b1111, 12'd0,   2'b00};
        vecs[2] = '{4'b0100, 1,   4'b0100, 12'd1,   2'b00};
        vecs[3] = '{4'b1010, 37,  4'b1010, 12'd37,  2'b00};
        vecs[4] = '{4'b1000, 15,  4'b1000, 12'd15,  2'b00};
        vecs[5] = '{4'b0011, 200, 4'b0011, 12'd200, 2'b00};

        rst        = 1'b1;
        clk_in_ref = 1'b0;
        clk_in     = '0;
        enable     = 1'b1;
        tick();
        check("reset_tag_big", tag_b, 0);
        check("reset_valid_big", valid_b, 0);
        check("reset_err_big", err_b, 0);
        check("reset_tag_small", tag_s, 0);

        // Single measurements: reference rises at slot 0, channels at slot dly.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            clk_in_ref = 1'b1;
            if (vecs[v].dly == 0) clk_in = vecs[v].ch_mask;
            seen = '0;
            for (int s = 1; s <= vecs[v].dly + 2; s++) begin
                tick();
                seen |= valid_b;
                if (s == vecs[v].dly) clk_in = vecs[v].ch_mask;
            end
            check($sformatf("vec%0d_quiet", v), seen, 0);
            tick();
            check($sformatf("vec%0d_valid", v), valid_b, vecs[v].exp_valid);
            for (int c = 0; c < NCH; c++) begin
                if (vecs[v].exp_valid[c]) begin
                    check($sformatf("vec%0d_tag_ch%0d", v, c), tag_big(c), {4'd0, vecs[v].exp_count});
                    check($sformatf("vec%0d_err_ch%0d", v, c), err_big(c), vecs[v].exp_err);
                end
            end
            if (vecs[v].dly <= 15) begin
                check($sformatf("vec%0d_valid_small", v), valid_s & vecs[v].ch_mask, vecs[v].exp_valid);
                for (int c = 0; c < NCH; c++) begin
                    if (vecs[v].exp_valid[c]) begin
                        check($sformatf("vec%0d_tag_small_ch%0d", v, c), tag_sml(c),
                              {2'd0, vecs[v].exp_count[3:0]});
                        check($sformatf("vec%0d_err_small_ch%0d", v, c), err_sml(c), vecs[v].exp_err);
                    end
                end
            end
            tick();
            check($sformatf("vec%0d_pulse_once", v), valid_b, 0);
        end

        // Missed edge then overflow; small instance overflows at 15 and ignores lone channel edges.
        do_reset();
        clk_in_ref = 1'b1;
        quiet(17, 1, 1, "ovf_wait1");
        tick();
        check("small_ovf1_valid", valid_s, 4'b1111);
        check("small_ovf1_tag", tag_sml(1), 6'h0F);
        check("small_ovf1_err", err_sml(1), 2'b10);
        check("big_no_ovf1", valid_b, 0);
        clk_in_ref = 1'b0;
        quiet(32, 1, 1, "ovf_wait2");
        clk_in_ref = 1'b1;
        quiet(2, 1, 1, "ovf_wait3");
        tick();
        check("missed_valid", valid_b, 4'b1111);
        check("missed_tag", tag_big(1), 16'h0032);
        check("missed_err", err_big(1), 2'b01);
        check("small_rearm_no_valid", valid_s, 0);
        clk_in_ref = 1'b0;
        quiet(14, 1, 1, "ovf_wait4");
        tick();
        check("small_ovf2_valid", valid_s, 4'b1111);
        check("small_ovf2_tag", tag_sml(1), 6'h1F);
        check("small_ovf2_err", err_sml(1), 2'b10);
        check("big_no_ovf2", valid_b, 0);
        quiet(4079, 1, 1, "ovf_wait5");
        tick();
        check("big_ovf_valid", valid_b, 4'b1111);
        check("big_ovf_tag", tag_big(1), 16'h1FFF);
        check("big_ovf_err", err_big(1), 2'b10);
        check("small_no_ovf3", valid_s, 0);
        quiet(1, 1, 1, "ovf_after");
        clk_in = 4'b0001;
        quiet(10, 1, 1, "idle_ch_edge");
        check("hold_tag", tag_big(1), 16'h1FFF);
        check("hold_err", err_big(1), 2'b10);
        clk_in = '0;

        // Reference counter wrap with a fixed channel-2 delay of 7, period 12.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            clk_in_ref = 1'b1;
            quiet(2, 1, 1, $sformatf("wrap%0d_a", k));
            tick();
            exp_v = (k > 0) ? 4'b1011 : 4'b0000;
            check($sformatf("wrap%0d_missed_valid", k), valid_b, exp_v);
            check($sformatf("wrap%0d_missed_valid_small", k), valid_s, exp_v);
            if (k > 0) begin
                check($sformatf("wrap%0d_missed_tag", k), tag_big(0), ((k - 1) << 12) | 12);
                check($sformatf("wrap%0d_missed_tag_small", k), tag_sml(0), (((k - 1) & 3) << 4) | 12);
                check($sformatf("wrap%0d_missed_err", k), err_big(0), 2'b01);
            end
            quiet(3, 1, 1, $sformatf("wrap%0d_b", k));
            clk_in_ref = 1'b0;
            quiet(1, 1, 1, $sformatf("wrap%0d_c", k));
            clk_in = 4'b0100;
            quiet(2, 1, 1, $sformatf("wrap%0d_d", k));
            tick();
            check($sformatf("wrap%0d_valid", k), valid_b, 4'b0100);
            check($sformatf("wrap%0d_tag", k), tag_big(2), (k << 12) | 7);
            check($sformatf("wrap%0d_err", k), err_big(2), 2'b00);
            check($sformatf("wrap%0d_tag_small", k), tag_sml(2), ((k & 3) << 4) | 7);
            clk_in = '0;
            quiet(2, 1, 1, $sformatf("wrap%0d_e", k));
        end

        // Enable gating with a channel edge and a reference edge while disabled.
        do_reset();
        clk_in_ref = 1'b1;
        quiet(6, 1, 1, "en_arm");
        enable     = 1'b0;
        clk_in_ref = 1'b0;
        quiet(2, 1, 1, "en_off_a");
        clk_in = 4'b1000;
        quiet(4, 1, 1, "en_off_b");
        clk_in_ref = 1'b1;
        clk_in     = '0;
        quiet(4, 1, 1, "en_off_c");
        clk_in_ref = 1'b0;
        quiet(4, 1, 1, "en_off_d");
        enable = 1'b1;
        quiet(5, 1, 1, "en_on_a");
        clk_in_ref = 1'b1;
        quiet(9, 1, 1, "en_rearm");
        clk_in = 4'b1000;
        quiet(2, 1, 1, "en_on_b");
        tick();
        check("en_meas_valid", valid_b, 4'b1000);
        check("en_meas_tag", tag_big(3), 16'h1009);
        check("en_meas_err", err_big(3), 2'b00);
        check("en_meas_valid_small", valid_s, 4'b1000);
        check("en_meas_tag_small", tag_sml(3), 6'h19);
        clk_in = '0;
        quiet(3, 1, 1, "pre_rst");

        // Asynchronous reset in the middle of a count.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_tag_big", tag_b, 0);
        check("async_rst_valid_big", valid_b, 0);
        check("async_rst_err_big", err_b, 0);
        check("async_rst_tag_small", tag_s, 0);
        clk_in_ref = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        quiet(20, 1, 1, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/phase_detector_multi.md
Name: phase_detector_multi

Overview:
Multi-channel start/stop phase detector sampled by one high-frequency clock. A shared reference clock edge starts an independent counter for each of NUM_CH measured clocks. Each channel's own rising edge stops its counter and emits a tagged delay measurement. Adds over the single-channel version: channel array, per-channel timeout/missed-edge error reporting, an enable gate, and a per-channel latched reference-period tag.

Parameters:
NUM_CH, 4, number of measured input clocks
phase_count_size, 12, width of per-channel delay counter
ref_count_size, 4, width of reference-edge counter embedded in tag

Ports:
clk_sample  in  1  high-frequency sample clock, the only clock
rst  in  1  reset, asynchronous and active-high
clk_in_ref  in  1  asynchronous reference clock (start event)
clk_in  in  NUM_CH  asynchronous measured clocks (stop events), bit i = channel i
enable  in  1  measurement enable, synchronous to clk_sample
phase_tag  out  NUM_CH*(ref_count_size+phase_count_size)  per-channel {ref_count, phase_count}, channel i at slice i
phase_tag_valid  out  NUM_CH  one-cycle pulse per channel when its tag/err updates
phase_err  out  NUM_CH*2  per-channel status with valid: 00 ok, 01 missed, 10 overflow

Behaviour:
- Reset (async assert, clocked release): all sync flops, delayed flops, counters, ref_count, states = 0/S_IDLE; phase_tag=0, phase_tag_valid=0, phase_err=0.
- Each of clk_in_ref and clk_in[i] passes a 2-flop synchronizer (reset to 0), then one delay flop; edge = sync & ~delayed (rising only).
- Latency: input high captured at sample edge k -> edge flag true after edge k+1 -> registered outputs change at edge k+2.
- ref_count: increments (wraps modulo 2^ref_count_size) on every ref edge while enable=1. Each channel latches the pre-increment ref_count at the edge that arms it.
- Per-channel FSM, S_IDLE / S_COUNT, all outputs registered; phase_tag_valid defaults to 0 each cycle.
- S_IDLE, ref_edge & ch_edge same cycle: valid=1, tag={ref_count, 0}, err=00, stay S_IDLE.
- S_IDLE, ref_edge only: count<=1, latch ref_count, go S_COUNT.
- S_IDLE, ch_edge only: ignored.
- S_COUNT, ch_edge (with or without ref_edge): valid=1, tag={latched, count}, err=00. If ref_edge also present: re-latch ref_count, count<=1, stay S_COUNT; else count<=0, go S_IDLE.
- S_COUNT, ref_edge only: valid=1, tag={latched, count}, err=01 (missed); re-latch ref_count, count<=1, stay S_COUNT.
- S_COUNT, no edges, count == all-ones: valid=1, tag={latched, all-ones}, err=10 (overflow), count<=0, go S_IDLE.
- S_COUNT, no edges, otherwise: count<=count+1.
- Reported count for ref edge at cycle r and channel edge at cycle c (identical sync paths) = c-r. Range 0..2^phase_count_size-1.
- enable=0: synchronizers/delay flops keep running; FSMs forced to S_IDLE; counts cleared; no valid pulses; ref_count holds. The first ref edge after enable returns arms normally.
- Channels are fully independent; any subset may pulse valid in the same cycle.
- phase_tag/phase_err hold their last value between valid pulses.
- Reset mid-measurement: immediate return to reset values; no valid generated on release.

Test Plan:
- Reset then ref rising, ch0 rising 10 sample cycles later (same alignment) -> ch0 valid one cycle, tag={0,10}, err=00; other channels no valid.
- ref and all 4 channels rise in same sample cycle -> valid=4'b1111 same cycle, each tag count=0, err=00.
- ref edges at cycles 0 and 50, ch1 never rises, phase_count_size=12 -> at the second ref edge ch1 valid, err=01, count=50; then after 4095 more cycles, valid with err=10, count=4095.
- phase_count_size=4, ref edge, no channel edge -> valid after count reaches 15, err=10, FSM returns to idle; a later ch edge alone produces no valid.
- Four ref edges with ch2 delay 7 each, then ref_count wrap test with ref_count_size=2 -> tags {0,7},{1,7},{2,7},{3,7},{0,7}.
- enable dropped while ch3 in S_COUNT, ch3 edge occurs, enable restored -> no valid during disable; the next ref->ch3 measurement is correct. Assert rst mid-count -> all outputs 0 immediately (async).
